// File: rtl/missile_pkg.sv
// missile_pkg: shared definitions for the missile pool.
//   slot_st_e  : per-slot FSM encoding (IDLE=00, FLY=01, CD=10; 11 is illegal)
//   dir_e      : flight direction latched at launch (0 = +x, 1 = -x)
//   DEF_*      : default screen geometry used as parameter defaults
//   popcount   : helper counting set bits of a slot vector
package missile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FLY  = 2'b01,
    ST_CD   = 2'b10
  } slot_st_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  localparam int DEF_SCR_W  = 640;
  localparam int DEF_SCR_H  = 480;
  localparam int DEF_MARGIN = 3;

  // Up to 8 slots, so a 4-bit result always fits.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/missile_slot.sv
// missile_slot: one missile. IDLE tracks the robot, FLY steps SPEED pixels per
// tick until off-screen (or hit), CD waits CD_TICKS ticks before IDLE again.
// Optional feature macro: MISSILE_HIT_CLEAR_EN (adds the hit input).
// Ports:
//   clk, rst   tick clock, async active-low reset
//   launch     grant from the pool arbiter (only honoured in IDLE)
//   dir        direction sampled at launch
//   r_x, r_y   robot position
//   hit        (MISSILE_HIT_CLEAR_EN only) target struck, FLY -> CD
//   state      registered FSM state
//   x, y       registered missile position
module missile_slot
  import missile_pkg::*;
#(
  parameter int XY_W     = 10,
  parameter int SPEED    = 50,
  parameter int CD_TICKS = 10,
  parameter int SCR_W    = DEF_SCR_W,
  parameter int SCR_H    = DEF_SCR_H,
  parameter int MARGIN   = DEF_MARGIN,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 140
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            launch,
  input  logic            dir,
  input  logic [XY_W-1:0] r_x,
  input  logic [XY_W-1:0] r_y,
`ifdef MISSILE_HIT_CLEAR_EN
  input  logic            hit,
`endif
  output slot_st_e        state,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y
);

  localparam int CW = (CD_TICKS > 1) ? $clog2(CD_TICKS) : 1;

  // Geometry compared in XY_W+1 bits so the step can be checked for overflow.
  localparam logic [XY_W:0] SPD = (XY_W+1)'(SPEED);
  localparam logic [XY_W:0] MAR = (XY_W+1)'(MARGIN);
  localparam logic [XY_W:0] SW  = (XY_W+1)'(SCR_W);
  localparam logic [XY_W:0] SH  = (XY_W+1)'(SCR_H);

  logic [CW-1:0]   cnt;
  dir_e            dir_q;
  logic [XY_W:0]   sum, diff;
  logic [XY_W-1:0] x_next;
  logic            off, hit_i;

`ifdef MISSILE_HIT_CLEAR_EN
  assign hit_i = hit;
`else
  assign hit_i = 1'b0;
`endif

  always_comb begin
    sum  = {1'b0, x} + SPD;
    diff = {1'b0, x} - SPD;
    // Borrow/carry saturate to an off-screen coordinate instead of wrapping.
    if (dir_q == DIR_LEFT) x_next = diff[XY_W] ? '0 : diff[XY_W-1:0];
    else                   x_next = sum[XY_W]  ? '1 : sum[XY_W-1:0];
    off = ({1'b0, x} < MAR) || ({1'b0, x} >= SW) ||
          ({1'b0, y} < MAR) || ({1'b0, y} >= SH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      x     <= XY_W'(INIT_X);
      y     <= XY_W'(INIT_Y);
      cnt   <= '0;
      dir_q <= DIR_RIGHT;
    end else begin
      case (state)
        ST_IDLE: begin
          x   <= r_x;
          y   <= r_y;
          cnt <= '0;
          if (launch) begin
            state <= ST_FLY;
            dir_q <= dir_e'(dir);
          end
        end
        ST_FLY: begin
          // Hit wins over the move; off-screen is judged on the current position.
          if (hit_i || off) state <= ST_CD;
          else              x     <= x_next;
        end
        ST_CD: begin
          if (cnt == CW'(CD_TICKS - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/missile_pool.sv
// missile_pool: N_SLOTS independent missiles fired from the robot.
// Lowest-index IDLE slot is granted when shoot_sign is high (one launch per
// tick); outputs are decoded combinationally from the registered slot states.
// Optional feature macro: MISSILE_HIT_CLEAR_EN (adds hit[N_SLOTS-1:0]).
// Ports:
//   clk_22, rst        tick clock, async active-low reset
//   shoot_sign         level fire request
//   shoot_dir          0 = +x, 1 = -x, latched at launch
//   r_x, r_y           robot position
//   hit                (MISSILE_HIT_CLEAR_EN only) per-slot target strike
//   m_x, m_y           packed slot positions, slot i at [i*XY_W +: XY_W]
//   show_valid         slot i in FLY
//   cd_sign            no slot IDLE
//   free_cnt           number of IDLE slots
module missile_pool
  import missile_pkg::*;
#(
  parameter int N_SLOTS  = 4,
  parameter int XY_W     = 10,
  parameter int SPEED    = 50,
  parameter int CD_TICKS = 10,
  parameter int SCR_W    = DEF_SCR_W,
  parameter int SCR_H    = DEF_SCR_H,
  parameter int MARGIN   = DEF_MARGIN,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 140
) (
  input  logic                      clk_22,
  input  logic                      rst,
  input  logic                      shoot_sign,
  input  logic                      shoot_dir,
  input  logic [XY_W-1:0]           r_x,
  input  logic [XY_W-1:0]           r_y,
`ifdef MISSILE_HIT_CLEAR_EN
  input  logic [N_SLOTS-1:0]        hit,
`endif
  output logic [N_SLOTS*XY_W-1:0]   m_x,
  output logic [N_SLOTS*XY_W-1:0]   m_y,
  output logic [N_SLOTS-1:0]        show_valid,
  output logic                      cd_sign,
  output logic [3:0]                free_cnt
);

  slot_st_e                         st [N_SLOTS];
  logic [N_SLOTS-1:0][XY_W-1:0]     slot_x, slot_y;
  logic [N_SLOTS-1:0]               idle, grant;

  // Isolate the lowest set bit of idle; a full pool yields no grant.
  assign grant = shoot_sign ? (idle & (~idle + N_SLOTS'(1))) : '0;

  genvar g;
  for (g = 0; g < N_SLOTS; g++) begin : g_slot
    missile_slot #(
      .XY_W(XY_W), .SPEED(SPEED), .CD_TICKS(CD_TICKS),
      .SCR_W(SCR_W), .SCR_H(SCR_H), .MARGIN(MARGIN),
      .INIT_X(INIT_X), .INIT_Y(INIT_Y)
    ) u_slot (
      .clk    (clk_22),
      .rst    (rst),
      .launch (grant[g]),
      .dir    (shoot_dir),
      .r_x    (r_x),
      .r_y    (r_y),
`ifdef MISSILE_HIT_CLEAR_EN
      .hit    (hit[g]),
`endif
      .state  (st[g]),
      .x      (slot_x[g]),
      .y      (slot_y[g])
    );
    assign idle[g]       = (st[g] == ST_IDLE);
    assign show_valid[g] = (st[g] == ST_FLY);
  end

  assign m_x      = slot_x;
  assign m_y      = slot_y;
  assign free_cnt = popcount(8'(idle));
  assign cd_sign  = (free_cnt == 4'd0);

endmodule
